// File: rtl/fpu_issue_scheduler.sv
// rtl/fpu_issue_scheduler.sv - two-slot FPU issue arbiter with FP writeback-port hazard tracking
module fpu_issue_scheduler #(
    parameter int TAG_W       = 5,
    parameter int FMA_LAT     = 4,
    parameter int FAST_LAT    = 2,
    parameter int FROMINT_LAT = 2
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [1:0]       req_valid,
    output logic [1:0]       req_ready,
    input  logic [3:0]       req0_cls,
    input  logic [3:0]       req1_cls,
    input  logic [TAG_W-1:0] req0_tag,
    input  logic [TAG_W-1:0] req1_tag,
    input  logic             kill,
    output logic             issue_valid,
    output logic [3:0]       issue_cls,
    output logic [TAG_W-1:0] issue_tag,
    output logic             issue_src,
    output logic             fp_wb_valid,
    output logic [TAG_W-1:0] fp_wb_tag,
    output logic             int_wb_valid,
    output logic [TAG_W-1:0] int_wb_tag,
    output logic             int_wb_illegal,
    output logic             busy
);

    function automatic logic [3:0] resolve(input logic [3:0] c);
        if (c[0])      return 4'b0001;
        else if (c[1]) return 4'b0010;
        else if (c[2]) return 4'b0100;
        else if (c[3]) return 4'b1000;
        else           return 4'b0000;
    endfunction

    // slot[k] writes back k-1 cycles from now; slot_ext adds the always-empty slot[FMA_LAT+1]
    logic [FMA_LAT:1]   slot_v;
    logic [TAG_W-1:0]   slot_tag [1:FMA_LAT];
    logic [FMA_LAT+1:1] slot_ext;

    logic             rr;
    logic             int_v;
    logic [TAG_W-1:0] int_tag;
    logic             int_ill;

    logic [3:0]       res0, res1, g_res;
    logic [1:0]       elig;
    logic             grant_any, grant_idx, g_fp, g_int;
    logic [TAG_W-1:0] g_tag;
    int               wr_lat;

    assign slot_ext = {1'b0, slot_v};
    assign res0     = resolve(req0_cls);
    assign res1     = resolve(req1_cls);

    // a grant at latency L lands in slot[L], which collides only with whatever shifts down from slot[L+1]
    always_comb begin
        elig[0] = req_valid[0] & ~kill
                & ~((res0[0] & slot_ext[FMA_LAT+1]) | (res0[1] & slot_ext[FAST_LAT+1])
                  | (res0[2] & slot_ext[FROMINT_LAT+1]));
        elig[1] = req_valid[1] & ~kill
                & ~((res1[0] & slot_ext[FMA_LAT+1]) | (res1[1] & slot_ext[FAST_LAT+1])
                  | (res1[2] & slot_ext[FROMINT_LAT+1]));
    end

    always_comb begin
        grant_any = |elig;
        grant_idx = (&elig) ? rr : elig[1];
        req_ready = 2'b00;
        if (grant_any) req_ready = grant_idx ? 2'b10 : 2'b01;
        g_res  = grant_idx ? res1 : res0;
        g_tag  = grant_idx ? req1_tag : req0_tag;
        g_fp   = grant_any & (|g_res[2:0]);
        g_int  = grant_any & ~(|g_res[2:0]);
        wr_lat = g_res[0] ? FMA_LAT : (g_res[1] ? FAST_LAT : FROMINT_LAT);
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            slot_v <= '0;
            for (int k = 1; k <= FMA_LAT; k++) slot_tag[k] <= '0;
        end else if (kill) begin
            slot_v <= '0;
        end else begin
            for (int k = 1; k < FMA_LAT; k++) begin
                slot_v[k]   <= slot_v[k+1];
                slot_tag[k] <= slot_tag[k+1];
            end
            slot_v[FMA_LAT] <= 1'b0;
            if (g_fp) begin
                for (int k = 1; k <= FMA_LAT; k++) begin
                    if (k == wr_lat) begin
                        slot_v[k]   <= 1'b1;
                        slot_tag[k] <= g_tag;
                    end
                end
            end
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            rr          <= 1'b0;
            issue_valid <= 1'b0;
            issue_cls   <= '0;
            issue_tag   <= '0;
            issue_src   <= 1'b0;
            int_v       <= 1'b0;
            int_tag     <= '0;
            int_ill     <= 1'b0;
        end else begin
            issue_valid <= grant_any;
            if (grant_any) begin
                rr        <= ~grant_idx;
                issue_cls <= g_res;
                issue_tag <= g_tag;
                issue_src <= grant_idx;
            end
            if (g_int) begin
                int_v   <= 1'b1;
                int_tag <= g_tag;
                int_ill <= (g_res == 4'b0000);
            end else begin
                int_v   <= 1'b0;
                int_tag <= '0;
                int_ill <= 1'b0;
            end
        end
    end

    assign fp_wb_valid    = slot_v[1] & ~kill;
    assign fp_wb_tag      = slot_tag[1];
    assign int_wb_valid   = int_v & ~kill;
    assign int_wb_tag     = int_tag;
    assign int_wb_illegal = int_ill & int_wb_valid;
    assign busy           = issue_valid | int_v | (|slot_v);

endmodule

// File: tb/tb_fpu_issue_scheduler.sv
// tb/tb_fpu_issue_scheduler.sv - scoreboard bench for fpu_issue_scheduler
module tb_fpu_issue_scheduler;
    localparam int TAG_W       = 5;
    localparam int FMA_LAT     = 4;
    localparam int FAST_LAT    = 2;
    localparam int FROMINT_LAT = 2;

    logic             clock = 1'b0;
    logic             reset;
    logic [1:0]       req_valid, req_ready;
    logic [3:0]       req0_cls, req1_cls;
    logic [TAG_W-1:0] req0_tag, req1_tag;
    logic             kill;
    logic             issue_valid, issue_src, fp_wb_valid, int_wb_valid, int_wb_illegal, busy;
    logic [3:0]       issue_cls;
    logic [TAG_W-1:0] issue_tag, fp_wb_tag, int_wb_tag;

    fpu_issue_scheduler #(
        .TAG_W(TAG_W), .FMA_LAT(FMA_LAT), .FAST_LAT(FAST_LAT), .FROMINT_LAT(FROMINT_LAT)
    ) dut (
        .clock(clock), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
        .req0_cls(req0_cls), .req1_cls(req1_cls), .req0_tag(req0_tag), .req1_tag(req1_tag),
        .kill(kill), .issue_valid(issue_valid), .issue_cls(issue_cls), .issue_tag(issue_tag),
        .issue_src(issue_src), .fp_wb_valid(fp_wb_valid), .fp_wb_tag(fp_wb_tag),
        .int_wb_valid(int_wb_valid), .int_wb_tag(int_wb_tag), .int_wb_illegal(int_wb_illegal),
        .busy(busy)
    );

    always #5 clock = ~clock;

    typedef struct {
        int               cyc;
        logic [3:0]       cls;
        logic [TAG_W-1:0] tag;
        logic             src;
        logic             ill;
    } ev_t;

    typedef struct {
        int       cyc;
        logic [1:0] rdy;
        logic     busy;
    } ctl_t;

    ev_t  issq[$];
    ev_t  fpq[$];
    ev_t  intq[$];
    ctl_t ctlq[$];
    int   cyc = 0;
    int   checks = 0;
    int   passed = 0;
    bit   rr_m = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s cyc=%0d actual=%0h required=%0h", name, cyc, act, exp);
    endtask

    function automatic logic [3:0] ref_class(input logic [3:0] c);
        logic [3:0] one = 4'b0001;
        for (int b = 0; b < 4; b++) if (c[b]) return one << b;
        return 4'b0000;
    endfunction

    function automatic int ref_lat(input logic [3:0] r);
        case (r)
            4'b0001: return FMA_LAT;
            4'b0010: return FAST_LAT;
            4'b0100: return FROMINT_LAT;
            default: return 0;
        endcase
    endfunction

    function automatic bit wb_taken(input int at);
        foreach (fpq[j]) if (fpq[j].cyc == at) return 1'b1;
        return 1'b0;
    endfunction

    // one cycle of stimulus plus the reference model's view of that cycle
    task automatic step(input logic [1:0] v, input logic [3:0] c0, input logic [TAG_W-1:0] t0,
                        input logic [3:0] c1, input logic [TAG_W-1:0] t1, input logic k);
        logic [3:0]       r [2];
        logic [TAG_W-1:0] t [2];
        bit               el [2];
        int               g, idx, l;
        ctl_t             c;
        ev_t              e;
        @(posedge clock);
        cyc++;
        #1;
        reset = 1'b1;
        req_valid = v; req0_cls = c0; req1_cls = c1; req0_tag = t0; req1_tag = t1; kill = k;
        r[0] = ref_class(c0); r[1] = ref_class(c1); t[0] = t0; t[1] = t1;
        c.cyc  = cyc;
        c.busy = (issq.size() + fpq.size() + intq.size()) != 0;
        if (k) begin
            fpq.delete();
            intq.delete();
        end
        for (int i = 0; i < 2; i++) begin
            l = ref_lat(r[i]);
            el[i] = v[i] && !k && !(l > 0 && wb_taken(cyc + l));
        end
        g = -1;
        if (el[0] && el[1]) g = rr_m ? 1 : 0;
        else if (el[0]) g = 0;
        else if (el[1]) g = 1;
        c.rdy = 2'b00;
        if (g >= 0) c.rdy[g] = 1'b1;
        ctlq.push_back(c);
        if (g >= 0) begin
            rr_m  = (g == 0);
            e.cyc = cyc + 1; e.cls = r[g]; e.tag = t[g]; e.src = (g == 1); e.ill = (r[g] == 4'b0000);
            issq.push_back(e);
            l = ref_lat(r[g]);
            if (l > 0) begin
                e.cyc = cyc + l;
                idx = fpq.size();
                for (int j = 0; j < fpq.size(); j++) begin
                    if (fpq[j].cyc > e.cyc) begin
                        idx = j;
                        break;
                    end
                end
                fpq.insert(idx, e);
            end else begin
                intq.push_back(e);
            end
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(2'b00, 4'h0, '0, 4'h0, '0, 1'b0);
    endtask

    task automatic do_reset();
        @(posedge clock);
        cyc++;
        #1;
        req_valid = 2'b00;
        kill = 1'b0;
        #2;
        reset = 1'b0;
        #1;
        chk("reset_outputs", {issue_valid, fp_wb_valid, int_wb_valid, int_wb_illegal, busy, req_ready,
                              issue_cls, issue_tag, issue_src, fp_wb_tag, int_wb_tag}, 64'd0);
        issq.delete(); fpq.delete(); intq.delete(); ctlq.delete();
        rr_m = 1'b0;
    endtask

    function automatic logic [3:0] rand_cls();
        int r = $urandom_range(0, 9);
        if (r < 3) return 4'b0001;
        if (r < 5) return 4'b0010;
        if (r < 6) return 4'b0100;
        if (r < 7) return 4'b1000;
        if (r < 8) return 4'b0000;
        return 4'($urandom_range(0, 15));
    endfunction

    always @(negedge clock) begin
        if (reset) begin
            if (ctlq.size() > 0 && ctlq[0].cyc == cyc) begin
                chk("req_ready", req_ready, ctlq[0].rdy);
                chk("busy", busy, ctlq[0].busy);
                void'(ctlq.pop_front());
            end
            if (issq.size() > 0 && issq[0].cyc == cyc) begin
                chk("issue_valid", issue_valid, 1);
                chk("issue_fields", {issue_cls, issue_tag, issue_src}, {issq[0].cls, issq[0].tag, issq[0].src});
                void'(issq.pop_front());
            end else if (issue_valid) begin
                chk("issue_unexpected", issue_valid, 0);
            end
            if (fpq.size() > 0 && fpq[0].cyc == cyc) begin
                chk("fp_wb_valid", fp_wb_valid, 1);
                chk("fp_wb_tag", fp_wb_tag, fpq[0].tag);
                void'(fpq.pop_front());
            end else if (fp_wb_valid) begin
                chk("fp_wb_unexpected", fp_wb_valid, 0);
            end
            if (intq.size() > 0 && intq[0].cyc == cyc) begin
                chk("int_wb_valid", int_wb_valid, 1);
                chk("int_wb_fields", {int_wb_tag, int_wb_illegal}, {intq[0].tag, intq[0].ill});
                void'(intq.pop_front());
            end else if (int_wb_valid) begin
                chk("int_wb_unexpected", int_wb_valid, 0);
            end
        end
    end

    initial begin
        reset = 1'b0; req_valid = 2'b00; req0_cls = '0; req1_cls = '0;
        req0_tag = '0; req1_tag = '0; kill = 1'b0;
        repeat (2) @(posedge clock);
        #1;
        chk("reset_state", {issue_valid, fp_wb_valid, int_wb_valid, int_wb_illegal, busy, req_ready,
                            issue_cls, issue_tag, issue_src, fp_wb_tag, int_wb_tag}, 64'd0);

        step(2'b01, 4'b0001, 5'd5, 4'h0, '0, 1'b0);
        idle(6);

        do_reset();
        repeat (4) step(2'b11, 4'b1000, 5'd1, 4'b1000, 5'd2, 1'b0);
        idle(2);

        step(2'b01, 4'b0001, 5'd3, 4'h0, '0, 1'b0);
        repeat (4) step(2'b10, 4'h0, '0, 4'b0010, 5'd7, 1'b0);
        idle(6);

        step(2'b01, 4'b0000, 5'd9, 4'h0, '0, 1'b0);
        idle(2);

        step(2'b01, 4'b0001, 5'd4, 4'h0, '0, 1'b0);
        idle(1);
        step(2'b11, 4'b0001, 5'd6, 4'b0010, 5'd8, 1'b1);
        idle(5);

        step(2'b01, 4'b0001, 5'd11, 4'h0, '0, 1'b0);
        idle(1);
        do_reset();
        idle(7);

        for (int n = 0; n < 1500; n++) begin
            if (n == 700) do_reset();
            step(2'($urandom_range(0, 3)), rand_cls(), 5'($urandom_range(0, 31)),
                 rand_cls(), 5'($urandom_range(0, 31)), ($urandom_range(0, 29) == 0));
        end
        idle(12);
        @(negedge clock);
        #1;
        chk("drain", issq.size() + fpq.size() + intq.size() + ctlq.size(), 0);
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
